// File: rtl/trng_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trng_word_fifo
// Purpose  : Show-ahead word FIFO behind the TRNG bit collector. It runs an
//            online repetition-count health test on incoming words. It also
//            counts words dropped on overflow. A failed health test latches a
//            sticky alarm that blocks writes until software clears it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   wr_data      32-bit word from the collector
//   wr_valid     single-cycle strobe qualifying wr_data
//   rd_ready     reader accepts the head word this cycle
//   clear_alarm  synchronous clear of alarm, FIFO contents and counters
//   rd_data      head word (0 when empty)
//   rd_valid     FIFO non-empty
//   level        occupancy, 0..DEPTH
//   full         level == DEPTH
//   empty        level == 0
//   overflow_cnt words dropped while full (saturating)
//   rep_alarm    sticky repetition-test failure
// ============================================================================
module trng_word_fifo #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int REP_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wr_data,
    input  logic              wr_valid,
    input  logic              rd_ready,
    input  logic              clear_alarm,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
    output logic [15:0]       overflow_cnt,
    output logic              rep_alarm
);

    localparam logic [ADDR_W:0]   c_FULL_LEVEL = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   c_LEVEL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]        c_REP_LIMIT  = REP_LIMIT[7:0];

    logic [31:0]       r_mem [0:DEPTH-1];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [15:0]       r_overflow_cnt;
    logic              r_rep_alarm;
    logic [7:0]        r_rep_cnt;
    logic              r_have_last;
    logic [31:0]       r_last_word;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_wr_eval;
    logic              w_match;
    logic [7:0]        w_rep_cnt_next;
    logic              w_trip;
    logic              w_push;
    logic              w_drop_ovf;

    assign w_full  = (r_level == c_FULL_LEVEL);
    assign w_empty = (r_level == '0);

    // rd_ready while empty is simply ignored.
    assign w_pop = !w_empty && rd_ready;

    // The health test sees every strobed word, including words about to be
    // dropped for lack of space, but is frozen while the alarm is latched.
    // clear_alarm discards a same-cycle write entirely.
    assign w_wr_eval      = wr_valid && !r_rep_alarm && !clear_alarm;
    assign w_match        = r_have_last && (wr_data == r_last_word);
    assign w_rep_cnt_next = w_match ? (r_rep_cnt + 8'd1) : 8'd1;
    assign w_trip         = w_wr_eval && (w_rep_cnt_next == c_REP_LIMIT);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push     = w_wr_eval && !w_trip && (!w_full || w_pop);
    assign w_drop_ovf = w_wr_eval && !w_trip && w_full && !w_pop;

    // Storage has no reset: pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_overflow_cnt <= '0;
            r_rep_alarm    <= 1'b0;
            r_rep_cnt      <= '0;
            r_have_last    <= 1'b0;
            r_last_word    <= '0;
        end else if (clear_alarm) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_overflow_cnt <= '0;
            r_rep_alarm    <= 1'b0;
            r_rep_cnt      <= '0;
            r_have_last    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            if (w_push && !w_pop) begin
                r_level <= r_level + c_LEVEL_ONE;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - c_LEVEL_ONE;
            end

            if (w_drop_ovf && (r_overflow_cnt != 16'hFFFF)) begin
                r_overflow_cnt <= r_overflow_cnt + 16'd1;
            end

            // On a trip rep_cnt lands exactly on REP_LIMIT and then freezes
            // with the alarm, so it never exceeds the limit.
            if (w_wr_eval) begin
                r_last_word <= wr_data;
                r_have_last <= 1'b1;
                r_rep_cnt   <= w_rep_cnt_next;
                if (w_trip) begin
                    r_rep_alarm <= 1'b1;
                end
            end
        end
    end

    assign rd_valid     = !w_empty;
    assign rd_data      = w_empty ? 32'h0 : r_mem[r_rd_ptr];
    assign level        = r_level;
    assign full         = w_full;
    assign empty        = w_empty;
    assign overflow_cnt = r_overflow_cnt;
    assign rep_alarm    = r_rep_alarm;

endmodule
`default_nettype wire

// File: doc/trng_word_fifo.md
Name: trng_word_fifo

Overview:
- Downstream stage of the TRNG top: consumes the 32-bit words and per-word valid strobe from the bit collector.
- Buffers words in a show-ahead FIFO for a valid/ready reader (bus bridge / DMA).
- Runs an online repetition-count health test on incoming words and counts words dropped on overflow.
- A failed health test latches a sticky alarm and blocks further writes until software clears it.

Parameters:
- DEPTH, 16, FIFO depth in words; power of two, ≥ 2.
- ADDR_W, 4, log2(DEPTH).
- REP_LIMIT, 3, number of consecutive identical incoming words that trips the alarm; range 2..255.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- wr_data  in  32  word from collector.
- wr_valid  in  1  single-cycle strobe; wr_data is valid this cycle.
- rd_ready  in  1  reader accepts the head word this cycle.
- clear_alarm  in  1  single-cycle synchronous clear of alarm, FIFO and counters.
- rd_data  out  32  head word; valid when rd_valid=1.
- rd_valid  out  1  FIFO non-empty.
- level  out  ADDR_W+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow_cnt  out  16  words dropped because the FIFO was full; saturates at 0xFFFF.
- rep_alarm  out  1  sticky repetition-test failure.

Behaviour:
- Reset (async assert, sync release): pointers = 0, level = 0, empty = 1, full = 0, rd_valid = 0, rd_data = 0, overflow_cnt = 0, rep_alarm = 0, rep_cnt = 0, have_last = 0, last_word = 0.
- Storage: memory array with ADDR_W-bit read/write pointers that wrap naturally at DEPTH. level is a separate counter.
- Show-ahead read:
  - rd_valid = !empty.
  - rd_data = mem[rd_ptr] while rd_valid = 1; rd_data = 0 when empty.
  - Pop occurs on the clock edge where rd_valid & rd_ready. rd_ready while empty is ignored.
- Write latency: a word accepted at edge N is visible on rd_data/rd_valid immediately after edge N.
- Push accepted when all of the following hold: wr_valid, !rep_alarm, the repetition test does not trip this cycle, and (!full or pop this cycle).
- Simultaneous push + pop: level unchanged, both pointers advance. This holds when full; the word is accepted and nothing is dropped. When empty, pop does not occur; the push is accepted and level becomes 1.
- Overflow: wr_valid & full & no pop & !rep_alarm & no trip → word dropped, overflow_cnt += 1 (saturating).
- Words dropped because of the alarm are not counted in overflow_cnt.
- Repetition test (evaluated on every wr_valid, including words dropped for full; not evaluated while rep_alarm = 1):
  - If have_last & wr_data == last_word: rep_cnt_next = rep_cnt + 1; otherwise rep_cnt_next = 1.
  - last_word ← wr_data; have_last ← 1.
  - If rep_cnt_next == REP_LIMIT: rep_alarm ← 1 on that edge, and the tripping word is dropped.
  - rep_cnt is 8 bits wide and never exceeds REP_LIMIT.
- While rep_alarm = 1:
  - All writes are dropped; rep_cnt and last_word are frozen.
  - Reads continue normally, so buffered words already accepted remain readable.
- clear_alarm (highest priority, overrides same-cycle push/pop):
  - Pointers ← 0, level ← 0, overflow_cnt ← 0, rep_alarm ← 0, rep_cnt ← 0, have_last ← 0.
  - A wr_valid in the same cycle is discarded. Ports rd_data/rd_valid reflect empty on the next cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; no partial words survive.
- full and empty are registered-consistent with level; they are never asserted together.

Test Plan:
- Fill and drain: write 0x00000001..0x00000010 (16 words), rd_ready = 0 → full = 1, level = 16. Then rd_ready = 1 → rd_data sequence 0x1..0x10, empty = 1 after the 16th pop, overflow_cnt = 0.
- Overflow: with the FIFO full and rd_ready = 0, write 3 further distinct words → overflow_cnt = 3, level = 16, the head word is still 0x00000001. Repeat with push + pop in the same cycle while full → word accepted, overflow_cnt unchanged.
- Repetition trip (REP_LIMIT = 3): write 0xDEADBEEF three times → first two words stored (level = 2), third dropped, rep_alarm = 1. A further write of 0x12345678 is dropped; level stays 2 and overflow_cnt stays 0.
- Near miss: write A, A, B, A, A (A = 0xAAAAAAAA, B = 0x55555555) → no alarm, level = 5.
- clear_alarm: after the trip, pulse clear_alarm together with wr_valid → next cycle level = 0, rep_alarm = 0, overflow_cnt = 0. A subsequent 0xDEADBEEF write is accepted with rep_cnt = 1.
- Async reset mid-stream: assert rst between clock edges with level = 5 → empty = 1, rd_valid = 0, rd_data = 0 immediately, without waiting for a clock edge.
